register_file: RTL and testbench

//   MIPS general-purpose register file: 2^ADDR_WIDTH registers of DATA_WIDTH bits,
//   two combinational read ports and one synchronous write port.
//   - Write side is the 1-to-N counterpart of the datapath muxes: a decoded demux

---
 rtl/register_file.sv | 72 +++++++
 tb/tb_register_file.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// MIPS register file: 2R1W, register 0 hardwired to zero, optional write-to-read bypass.
// Reads are zero-cycle combinational, the write lands on the clock edge; no backpressure (always ready).
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  input  logic [ADDR_WIDTH-1:0] dbg_reg,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int NREGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NREGS];
  logic [DATA_WIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0]      wr_sel;
  logic                  wr_en;

  assign wr_en = reg_write && (write_reg != '0);

  // One-hot write decode; index 0 never gets a select line.
  always_comb begin
    wr_sel = '0;
    if (wr_en) wr_sel[write_reg] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_sel[i]) regs_d[i] = write_data;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Reset and index 0 override the bypass so a pending write can never leak out.
  always_comb begin
    read_data1 = regs_q[read_reg1];
    if ((BYPASS != 0) && wr_en && (write_reg == read_reg1)) read_data1 = write_data;
    if (!rst_n || (read_reg1 == '0)) read_data1 = '0;
  end

  always_comb begin
    read_data2 = regs_q[read_reg2];
    if ((BYPASS != 0) && wr_en && (write_reg == read_reg2)) read_data2 = write_data;
    if (!rst_n || (read_reg2 == '0)) read_data2 = '0;
  end

  always_comb begin
    dbg_data = regs_q[dbg_reg];
    if (!rst_n || (dbg_reg == '0)) dbg_data = '0;
  end

  a_reg_write_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(reg_write));

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reg_write = 1'b0;
  logic [4:0]  write_reg = '0;
  logic [31:0] write_data = '0;
  logic [4:0]  read_reg1 = '0;
  logic [4:0]  read_reg2 = '0;
  logic [4:0]  dbg_reg = '0;
  logic [31:0] rd1_b, rd2_b, dbg_b;
  logic [31:0] rd1_n, rd2_n, dbg_n;

  int errs = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  logic [31:0] model [32];

  always #50 clk = ~clk;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(rd1_b), .read_data2(rd2_b), .dbg_reg(dbg_reg), .dbg_data(dbg_b)
  );

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(rd1_n), .read_data2(rd2_n), .dbg_reg(dbg_reg), .dbg_data(dbg_n)
  );

  // Architectural model: an array of 32 words, cleared by reset, written on edges.
  initial for (int i = 0; i < 32; i++) model[i] = '0;

  always @(negedge rst_n) for (int i = 0; i < 32; i++) model[i] = '0;

  always @(posedge clk)
    if (rst_n === 1'b1 && reg_write === 1'b1 && write_reg != 0) model[write_reg] = write_data;

  function automatic logic [31:0] exp_read(input logic [4:0] idx, input bit byp);
    if (rst_n !== 1'b1 || idx == 0) return 32'h0;
    if (byp && reg_write === 1'b1 && write_reg != 0 && write_reg == idx) return write_data;
    return model[idx];
  endfunction

  function automatic logic [31:0] exp_dbg(input logic [4:0] idx);
    if (rst_n !== 1'b1) return 32'h0;
    return model[idx];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc rd1 byp",   rd1_b, exp_read(read_reg1, 1'b1));
      chk("cyc rd2 byp",   rd2_b, exp_read(read_reg2, 1'b1));
      chk("cyc dbg byp",   dbg_b, exp_dbg(dbg_reg));
      chk("cyc rd1 nobyp", rd1_n, exp_read(read_reg1, 1'b0));
      chk("cyc rd2 nobyp", rd2_n, exp_read(read_reg2, 1'b0));
      chk("cyc dbg nobyp", dbg_n, exp_dbg(dbg_reg));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] val);
    reg_write = 1'b1; write_reg = idx; write_data = val;
    step();
    reg_write = 1'b0;
  endtask

  initial begin
    cmp_en = 1'b1;
    #10;
    chk("reset rd1", rd1_b, 32'h0);
    chk("reset dbg", dbg_b, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Write/read with neighbours untouched
    wr(5'd5, 32'hDEADBEEF);
    read_reg1 = 5'd5; read_reg2 = 5'd4; dbg_reg = 5'd6;
    #1;
    chk("wr5 rd1", rd1_b, 32'hDEADBEEF);
    chk("wr5 reg4", rd2_b, 32'h0);
    chk("wr5 reg6", dbg_b, 32'h0);
    step();

    // Zero register, bypass path active
    reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hFFFFFFFF;
    read_reg1 = 5'd0; read_reg2 = 5'd0; dbg_reg = 5'd0;
    #1;
    chk("r0 byp rd1", rd1_b, 32'h0);
    chk("r0 byp rd2", rd2_b, 32'h0);
    step();
    reg_write = 1'b0;
    #1;
    chk("r0 post rd1", rd1_b, 32'h0);
    chk("r0 post dbg", dbg_b, 32'h0);

    // Bypass vs stored value
    wr(5'd7, 32'h1);
    reg_write = 1'b1; write_reg = 5'd7; write_data = 32'h2;
    read_reg2 = 5'd7; dbg_reg = 5'd7;
    #1;
    chk("byp rd2 B1", rd2_b, 32'h2);
    chk("byp rd2 B0", rd2_n, 32'h1);
    chk("byp dbg", dbg_b, 32'h1);
    step();
    reg_write = 1'b0;
    #1;
    chk("byp dbg post", dbg_b, 32'h2);
    chk("byp rd2 B0 post", rd2_n, 32'h2);

    // Walk all registers, read symmetric pairs
    for (int i = 1; i < 32; i++) wr(5'(i), i * 32'h01010101);
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i); read_reg2 = 5'(31 - i); dbg_reg = 5'(i);
      #1;
      chk("walk rd1", rd1_b, i * 32'h01010101);
      chk("walk rd2", rd2_b, (31 - i) * 32'h01010101);
      step();
    end

    // Async reset between edges clears everything immediately
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) begin
      dbg_reg = 5'(i); read_reg1 = 5'(i); read_reg2 = 5'(31 - i);
      #1;
      chk("arst dbg", dbg_b, 32'h0);
      chk("arst rd1", rd1_b, 32'h0);
      chk("arst rd2", rd2_b, 32'h0);
    end
    #7;
    rst_n = 1'b1;
    step();
    dbg_reg = 5'd31;
    #1;
    chk("arst stays clear", dbg_b, 32'h0);

    // Reset asserted during a pending write wins
    reg_write = 1'b1; write_reg = 5'd9; write_data = 32'hA5A5A5A5; dbg_reg = 5'd9;
    read_reg1 = 5'd9;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst rd1", rd1_b, 32'h0);
    step();
    chk("mid rst dbg", dbg_b, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("mid rst held", dbg_b, 32'h0);
    step();
    reg_write = 1'b0;
    #1;
    chk("post rst write", dbg_b, 32'hA5A5A5A5);
    step();
    step();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
